// File: rtl/vga_trace_plotter.sv
// Multi-channel VGA trace plotter: triggered, decimated capture into a double-buffered
// line store, rendered as connected traces over a dim graticule.
module vga_trace_plotter #(
    parameter int          SAMPLE_W = 8,
    parameter int          NUM_CH   = 2,
    parameter int          H_ACTIVE = 640,
    parameter int          V_OFFSET = 100,
    parameter logic [11:0] GRID_RGB = 12'h444,
    parameter logic [47:0] CH_RGB   = {12'hFF0, 12'h0FF, 12'hF0F, 12'h0F0}
) (
    input  logic                       Clk,
    input  logic                       vgaRst,
    input  logic                       sampleValid,
    input  logic [NUM_CH*SAMPLE_W-1:0] sampleData,
    input  logic [SAMPLE_W-1:0]        trigLevel,
    input  logic [1:0]                 trigMode,
    input  logic                       armSingle,
    input  logic [3:0]                 decim,
    input  logic [9:0]                 hColorCount,
    input  logic [9:0]                 vColorCount,
    input  logic                       displayEn,
    input  logic                       frameEnd,
    output logic [3:0]                 red,
    output logic [3:0]                 green,
    output logic [3:0]                 blue,
    output logic                       captureBusy,
    output logic                       triggered
);

    typedef enum logic [1:0] {ARMED, CAPTURE, HOLD, STOPPED} state_t;

    localparam int          AW       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int          PW       = NUM_CH * 8;
    localparam logic [AW-1:0] LAST_COL = AW'(H_ACTIVE - 1);
    localparam logic [10:0] H_LIM    = 11'(H_ACTIVE);
    localparam logic [10:0] V_OFF    = 11'(V_OFFSET);

    state_t              state;
    logic [1:0]          modeReg;
    logic [3:0]          decimReg;
    logic [3:0]          decimCnt;
    logic [AW-1:0]       wrIdx;
    logic                writeBank;
    logic                displayValid;
    logic [SAMPLE_W-1:0] prevCh0;

    logic [PW-1:0] lineStore [0:1][0:H_ACTIVE-1];

    logic [PW-1:0]       plotWord;
    logic [SAMPLE_W-1:0] curCh0;
    logic                crossing;
    logic                startCond;
    logic                wrEn;
    logic [AW-1:0]       wrAddr;

    logic [AW-1:0]       rdIdx;
    logic [AW-1:0]       rdPrevIdx;
    logic [PW-1:0]       curWord;
    logic [PW-1:0]       prevWord;
    logic [10:0]         yPos;
    logic                inPlot;
    logic                inColumns;
    logic [NUM_CH-1:0]   lit;
    logic [11:0]         pixel;

    assign curCh0    = sampleData[SAMPLE_W-1:0];
    assign crossing  = (prevCh0 < trigLevel) && (curCh0 >= trigLevel);
    assign startCond = (trigMode == 2'd0) || crossing;
    assign wrEn      = !vgaRst && sampleValid &&
                       ((state == ARMED && startCond) || (state == CAPTURE && decimCnt == 4'd0));
    assign wrAddr    = (state == CAPTURE) ? wrIdx : '0;

    // Render reads from the bank that capture is not filling.
    assign inColumns = {1'b0, hColorCount} < H_LIM;
    assign rdIdx     = inColumns ? hColorCount[AW-1:0] : '0;
    assign rdPrevIdx = (rdIdx == '0) ? '0 : rdIdx - AW'(1);
    assign curWord   = lineStore[~writeBank][rdIdx];
    assign prevWord  = lineStore[~writeBank][rdPrevIdx];
    assign yPos      = {1'b0, vColorCount} - V_OFF;
    assign inPlot    = (yPos[10:8] == 3'd0);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [7:0] curP;
        logic [7:0] prevP;
        logic [7:0] lo;
        logic [7:0] hi;
        // Plot value is the top byte of the inverted sample, so large samples sit high.
        assign plotWord[gi*8 +: 8] = ~sampleData[gi*SAMPLE_W + SAMPLE_W - 8 +: 8];
        assign curP    = curWord[gi*8 +: 8];
        assign prevP   = prevWord[gi*8 +: 8];
        assign lo      = (curP < prevP) ? curP : prevP;
        assign hi      = (curP < prevP) ? prevP : curP;
        assign lit[gi] = displayValid && inPlot && (yPos[7:0] >= lo) && (yPos[7:0] <= hi);
    end

    always_ff @(posedge Clk) begin
        if (wrEn) begin
            lineStore[writeBank][wrAddr] <= plotWord;
        end
    end

    always_ff @(posedge Clk or posedge vgaRst) begin
        if (vgaRst) begin
            state        <= ARMED;
            modeReg      <= 2'd0;
            decimReg     <= 4'd0;
            decimCnt     <= 4'd0;
            wrIdx        <= '0;
            writeBank    <= 1'b0;
            displayValid <= 1'b0;
            prevCh0      <= '1;
            captureBusy  <= 1'b0;
            triggered    <= 1'b0;
        end else begin
            triggered   <= 1'b0;
            captureBusy <= (state == ARMED) || (state == CAPTURE);
            if (sampleValid) begin
                prevCh0 <= curCh0;
            end
            case (state)
                ARMED: begin
                    if (sampleValid && startCond) begin
                        modeReg   <= trigMode;
                        decimReg  <= decim;
                        // The entering sample consumes decimation slot 0.
                        decimCnt  <= (decim == 4'd0) ? 4'd0 : 4'd1;
                        wrIdx     <= AW'(1);
                        triggered <= 1'b1;
                        if (H_ACTIVE == 1) begin
                            state       <= HOLD;
                            captureBusy <= 1'b0;
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (sampleValid) begin
                        decimCnt <= (decimCnt == decimReg) ? 4'd0 : decimCnt + 4'd1;
                        if (decimCnt == 4'd0) begin
                            wrIdx <= wrIdx + AW'(1);
                            if (wrIdx == LAST_COL) begin
                                state       <= HOLD;
                                captureBusy <= 1'b0;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (frameEnd) begin
                        writeBank    <= ~writeBank;
                        displayValid <= 1'b1;
                        if (modeReg == 2'd2) begin
                            state <= STOPPED;
                        end else begin
                            state       <= ARMED;
                            captureBusy <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (armSingle) begin
                        state       <= ARMED;
                        captureBusy <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pixel = 12'h000;
        if (displayEn && inColumns) begin
            if (inPlot && (hColorCount[5:0] == 6'd0 || yPos[5:0] == 6'd0)) begin
                pixel = GRID_RGB;
            end
            // Walk downwards so the lowest-numbered lit channel wins.
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                if (lit[c]) begin
                    pixel = CH_RGB[(3 - c) * 12 +: 12];
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge vgaRst) begin
        if (vgaRst) begin
            red   <= 4'd0;
            green <= 4'd0;
            blue  <= 4'd0;
        end else begin
            red   <= pixel[11:8];
            green <= pixel[7:4];
            blue  <= pixel[3:0];
        end
    end

endmodule
